// File: rtl/shift_serializer_pkg.sv
// Shared definitions for the shift_serializer block: FSM encoding and counter sizing.
package shift_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_t;

  // Counter width able to hold 0..nbits inclusive.
  function automatic int cnt_w(input int nbits);
    return $clog2(nbits + 1);
  endfunction

endpackage

// File: rtl/shift_serializer_bit_counter.sv
// Bit-position up-counter for the serializer; flags the final bit of a frame.
module bit_counter #(
  parameter int NBITS = 8,
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic last
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign last = (cnt == CNT_W'(NBITS - 1));

endmodule

// File: rtl/shift_serializer.sv
// Parallel-in/serial-out shifter with selectable bit order and idle level.
// Optional trailing parity bit is enabled by defining SHIFT_PARITY_EN.
module shift_serializer
  import shift_pkg::*;
#(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 0,
  parameter int IDLE_LEVEL = 0,
  parameter int ODD_PARITY = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             pause,
  input  logic [WIDTH-1:0] data_in,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

`ifdef SHIFT_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int CW = cnt_w(NBITS);
  localparam logic IDLE_BIT = (IDLE_LEVEL != 0);

  generate
    if (WIDTH < 2 || ODD_PARITY < 0 || ODD_PARITY > 1) begin : g_bad_param
      $error("shift_serializer: WIDTH must be >= 2 and ODD_PARITY 0 or 1");
    end
  endgenerate

  state_t           state;
  logic [NBITS-1:0] shreg;
  logic [WIDTH-1:0] ordered;
  logic [NBITS-1:0] frame;
  logic             accept;
  logic             advance;
  logic             last;

  // Frame is arranged so the first bit to send sits at index 0.
  always_comb begin
    ordered = data_in;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < WIDTH; i++) ordered[i] = data_in[WIDTH-1-i];
    end
  end

`ifdef SHIFT_PARITY_EN
  assign frame = {(^data_in) ^ (ODD_PARITY != 0), ordered};
`else
  assign frame = ordered;
`endif

  assign accept  = (state == ST_IDLE) && load;
  assign advance = (state == ST_SHIFT) && !pause && !last;

  bit_counter #(
    .NBITS(NBITS),
    .CNT_W(CW)
  ) u_bit_counter (
    .clk  (clk),
    .reset(reset),
    .clr  (accept),
    .en   (advance),
    .last (last)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      shreg      <= '0;
      serial_out <= IDLE_BIT;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (load) begin
            shreg      <= frame >> 1;
            serial_out <= frame[0];
            busy       <= 1'b1;
            state      <= ST_SHIFT;
          end else begin
            serial_out <= IDLE_BIT;
          end
        end
        ST_SHIFT: begin
          if (!pause) begin
            if (last) begin
              state      <= ST_IDLE;
              busy       <= 1'b0;
              done       <= 1'b1;
              serial_out <= IDLE_BIT;
            end else begin
              serial_out <= shreg[0];
              shreg      <= shreg >> 1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_serializer.sv
// Self-checking bench: an LSB-first/idle-low instance and an MSB-first/idle-high instance
// driven in lockstep against a per-cycle expected trace.
module tb_shift_serializer;

  localparam int W = 4;
`ifdef SHIFT_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         load;
  logic         pause;
  logic [W-1:0] data_in;
  logic         so_l, busy_l, done_l;
  logic         so_m, busy_m, done_m;

  always #5 clk = ~clk;

  shift_serializer #(.WIDTH(W), .MSB_FIRST(0), .IDLE_LEVEL(0), .ODD_PARITY(0)) u_lsb (
    .clk(clk), .reset(reset), .load(load), .pause(pause), .data_in(data_in),
    .serial_out(so_l), .busy(busy_l), .done(done_l)
  );

  shift_serializer #(.WIDTH(W), .MSB_FIRST(1), .IDLE_LEVEL(1), .ODD_PARITY(1)) u_msb (
    .clk(clk), .reset(reset), .load(load), .pause(pause), .data_in(data_in),
    .serial_out(so_m), .busy(busy_m), .done(done_m)
  );

  typedef struct {
    logic         load;
    logic         pause;
    logic [W-1:0] data;
    logic         so_l;
    logic         so_m;
    logic         busy;
    logic         done;
  } step_t;

  typedef struct {
    logic [W-1:0] data;
    int           pause_bit;
    int           pause_len;
    int           junk_bit;
    logic         pause_on_load;
    logic         trail;
  } vec_t;

  step_t q[$];
  int    checks = 0;
  int    errors = 0;

  // Bit sequence in send order; index W holds the parity bit.
  function automatic logic [W:0] seq(input logic [W-1:0] d, input logic msb, input logic odd);
    logic [W:0] s;
    for (int i = 0; i < W; i++) s[i] = msb ? d[W-1-i] : d[i];
    s[W] = (^d) ^ odd;
    return s;
  endfunction

  task automatic push(input logic ld, input logic ps, input logic [W-1:0] d,
                      input logic el, input logic em, input logic eb, input logic ed);
    step_t s;
    s.load = ld; s.pause = ps; s.data = d;
    s.so_l = el; s.so_m = em; s.busy = eb; s.done = ed;
    q.push_back(s);
  endtask

  task automatic add_frame(input vec_t v);
    logic [W:0]   sl;
    logic [W:0]   sm;
    logic [W-1:0] other;
    logic         jl;
    sl = seq(v.data, 1'b0, 1'b0);
    sm = seq(v.data, 1'b1, 1'b1);
    other = ~v.data;
    push(1'b1, v.pause_on_load, v.data, sl[0], sm[0], 1'b1, 1'b0);
    for (int i = 0; i < NB; i++) begin
      if (i == v.pause_bit) begin
        for (int k = 0; k < v.pause_len; k++) push(1'b0, 1'b1, other, sl[i], sm[i], 1'b1, 1'b0);
      end
      jl = (i == v.junk_bit);
      if (i < NB - 1)
        push(jl, 1'b0, jl ? 4'b0011 : other, sl[i+1], sm[i+1], 1'b1, 1'b0);
      else
        push(jl, 1'b0, jl ? 4'b0011 : other, 1'b0, 1'b1, 1'b0, 1'b1);
    end
    if (v.trail) push(1'b0, 1'b0, other, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic drain();
    step_t s;
    while (q.size() > 0) begin
      s = q.pop_front();
      @(negedge clk);
      load = s.load; pause = s.pause; data_in = s.data;
      @(posedge clk);
      #1;
      chk("serial_lsb", so_l,   s.so_l);
      chk("serial_msb", so_m,   s.so_m);
      chk("busy_lsb",   busy_l, s.busy);
      chk("done_lsb",   done_l, s.done);
      chk("busy_msb",   busy_m, s.busy);
      chk("done_msb",   done_m, s.done);
    end
    @(negedge clk);
    load = 1'b0; pause = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[6];
    vec_t b2b;
    vecs[0] = '{4'b1101, -1, 0, -1, 1'b0, 1'b1};
    vecs[1] = '{4'b1101,  1, 3, -1, 1'b0, 1'b1};
    vecs[2] = '{4'b1101, -1, 0,  1, 1'b0, 1'b1};
    vecs[3] = '{4'b0110, NB-1, 2, -1, 1'b0, 1'b1};
    vecs[4] = '{4'b1001, -1, 0, -1, 1'b1, 1'b1};
    vecs[5] = '{4'b1010,  0, 1, NB-1, 1'b0, 1'b1};

    reset = 1'b1; load = 1'b0; pause = 1'b0; data_in = '0;
    #12;
    chk("reset_serial_lsb", so_l, 1'b0);
    chk("reset_serial_msb", so_m, 1'b1);
    chk("reset_busy",       busy_l | busy_m, 1'b0);
    chk("reset_done",       done_l | done_m, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      add_frame(vecs[i]);
      drain();
    end

    // Back-to-back: second load lands in the done cycle of the first frame.
    b2b = '{4'b1101, -1, 0, -1, 1'b0, 1'b0};
    add_frame(b2b);
    b2b = '{4'b0011, -1, 0, -1, 1'b0, 1'b1};
    add_frame(b2b);
    drain();

    // Asynchronous reset in the middle of a frame.
    @(negedge clk);
    load = 1'b1; data_in = 4'b1101;
    @(posedge clk); #1;
    load = 1'b0;
    @(posedge clk); #1;
    chk("pre_reset_busy", busy_l, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("async_serial_lsb", so_l, 1'b0);
    chk("async_serial_msb", so_m, 1'b1);
    chk("async_busy",       busy_l | busy_m, 1'b0);
    chk("async_done",       done_l | done_m, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    add_frame(vecs[0]);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
